// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (core load/store + host loader/debug), one command per cycle.
// Optional round-robin contest resolution: define DMEM_ARB_ROUND_ROBIN_EN; default is fixed core priority.
module dmem_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_wr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              h_req,
  input  logic              h_wr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              m_rd,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  // Read-return tracking: bit 1 = core, bit 0 = host
  logic [1:0] rv_q, rv_d;
  logic       core_wins;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // last_h_q remembers which port was granted most recently; the other one wins a contest
  logic last_h_q, last_h_d;

  always_comb begin
    last_h_d = last_h_q;
    if (c_gnt || h_gnt) begin
      last_h_d = h_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_h_q <= 1'b1;
    end else begin
      last_h_q <= last_h_d;
    end
  end

  assign core_wins = last_h_q;
`else
  assign core_wins = 1'b1;
`endif

  // Grant decode; nothing is granted while reset is held
  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (!reset) begin
      if (c_req && h_req) begin
        c_gnt = core_wins;
        h_gnt = ~core_wins;
      end else begin
        c_gnt = c_req;
        h_gnt = h_req;
      end
    end
  end

  assign c_stall = c_req & ~c_gnt;

  // Memory command mux, zeroed when idle
  always_comb begin
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_rd    = ~c_wr;
      m_wr    = c_wr;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (h_gnt) begin
      m_rd    = ~h_wr;
      m_wr    = h_wr;
      m_addr  = h_addr;
      m_wdata = h_wdata;
    end
  end

  assign rv_d = {c_gnt & ~c_wr, h_gnt & ~h_wr};

  always_ff @(posedge clk) begin
    if (reset) begin
      rv_q <= 2'b00;
    end else begin
      rv_q <= rv_d;
    end
  end

  // A return that was in flight when reset arrived is masked immediately
  assign c_rvalid = rv_q[1] & ~reset;
  assign h_rvalid = rv_q[0] & ~reset;
  assign c_rdata  = c_rvalid ? m_rdata : '0;
  assign h_rdata  = h_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model.
// Expectations adapt to DMEM_ARB_ROUND_ROBIN_EN when the design is built with it.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_wr, c_gnt, c_rvalid, c_stall;
  logic [8:0]  c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic        h_req, h_wr, h_gnt, h_rvalid;
  logic [8:0]  h_addr;
  logic [31:0] h_wdata, h_rdata;
  logic        m_rd, m_wr;
  logic [8:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] mem [0:511];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // Synchronous memory: write-then-read next cycle sees the new word
  always @(posedge clk) begin
    if (m_wr) mem[m_addr] <= m_wdata;
    if (m_rd) m_rdata <= mem[m_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, apply a new command set, let it settle
  task automatic cyc(input logic cr, input logic cw, input logic [8:0] ca, input logic [31:0] cd,
                     input logic hr, input logic hw, input logic [8:0] ha, input logic [31:0] hd);
    @(posedge clk);
    #1;
    c_req = cr; c_wr = cw; c_addr = ca; c_wdata = cd;
    h_req = hr; h_wr = hw; h_addr = ha; h_wdata = hd;
    #1;
  endtask

  initial begin
    logic ecg, ecrv, ehrv;
    reset = 1'b1;
    c_req = 1'b1; c_wr = 1'b0; c_addr = 9'h010; c_wdata = 32'h0;
    h_req = 1'b0; h_wr = 1'b0; h_addr = 9'h000; h_wdata = 32'h0;
    #2;
    chk("rst_c_gnt", 32'(c_gnt), 32'd0);
    chk("rst_c_stall", 32'(c_stall), 32'd1);
    chk("rst_m_rd", 32'(m_rd), 32'd0);
    chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Preload through the host port
    cyc(0, 0, 9'h000, 32'h0, 1, 1, 9'h010, 32'hDEADBEEF);
    chk("pre_h_gnt", 32'(h_gnt), 32'd1);
    chk("pre_m_wr", 32'(m_wr), 32'd1);
    chk("pre_m_addr", 32'(m_addr), 32'h010);
    cyc(0, 0, 9'h000, 32'h0, 1, 1, 9'h020, 32'hCAFEF00D);
    chk("pre2_m_wdata", m_wdata, 32'hCAFEF00D);

    // Core read alone
    cyc(1, 0, 9'h010, 32'h0, 0, 0, 9'h000, 32'h0);
    chk("crd_c_gnt", 32'(c_gnt), 32'd1);
    chk("crd_m_rd", 32'(m_rd), 32'd1);
    chk("crd_c_stall", 32'(c_stall), 32'd0);
    chk("crd_m_addr", 32'(m_addr), 32'h010);
    // Host write to top address, read data of previous core read returns
    cyc(0, 0, 9'h000, 32'h0, 1, 1, 9'h1FF, 32'h12345678);
    chk("crd_c_rvalid", 32'(c_rvalid), 32'd1);
    chk("crd_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("crd_h_rvalid", 32'(h_rvalid), 32'd0);
    chk("hwr_h_gnt", 32'(h_gnt), 32'd1);
    cyc(1, 0, 9'h1FF, 32'h0, 0, 0, 9'h000, 32'h0);
    chk("raw_c_gnt", 32'(c_gnt), 32'd1);
    chk("hwr_no_rvalid", 32'(h_rvalid), 32'd0);
    cyc(1, 0, 9'h010, 32'h0, 0, 0, 9'h000, 32'h0);
    chk("raw_c_rdata", c_rdata, 32'h12345678);
    chk("raw_c_rvalid", 32'(c_rvalid), 32'd1);

    // Reset while a core read is in flight
    @(posedge clk);
    #1;
    reset = 1'b1; c_req = 1'b0;
    #1;
    chk("rst_fly_rvalid0", 32'(c_rvalid), 32'd0);
    chk("rst_fly_rdata0", c_rdata, 32'd0);
    cyc(0, 0, 9'h000, 32'h0, 0, 0, 9'h000, 32'h0);
    chk("rst_fly_rvalid1", 32'(c_rvalid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Both ports reading continuously from reset release
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc(1, 0, 9'h010, 32'h0, 1, 0, 9'h020, 32'h0);
      else begin
        c_req = 1'b1; c_wr = 1'b0; c_addr = 9'h010;
        h_req = 1'b1; h_wr = 1'b0; h_addr = 9'h020;
        #1;
      end
      ecg  = RR ? (i % 2 == 0) : 1'b1;
      ecrv = (i == 0) ? 1'b0 : (RR ? ((i - 1) % 2 == 0) : 1'b1);
      ehrv = (i == 0) ? 1'b0 : (RR ? ((i - 1) % 2 == 1) : 1'b0);
      chk($sformatf("both%0d_c_gnt", i), 32'(c_gnt), 32'(ecg));
      chk($sformatf("both%0d_h_gnt", i), 32'(h_gnt), 32'(!ecg));
      chk($sformatf("both%0d_c_stall", i), 32'(c_stall), 32'(!ecg));
      chk($sformatf("both%0d_c_rvalid", i), 32'(c_rvalid), 32'(ecrv));
      chk($sformatf("both%0d_h_rvalid", i), 32'(h_rvalid), 32'(ehrv));
      chk($sformatf("both%0d_c_rdata", i), c_rdata, ecrv ? 32'hDEADBEEF : 32'h0);
      chk($sformatf("both%0d_h_rdata", i), h_rdata, ehrv ? 32'hCAFEF00D : 32'h0);
    end

    // Core drops for one cycle: host gets it
    cyc(0, 0, 9'h010, 32'h0, 1, 0, 9'h020, 32'h0);
    chk("drop_h_gnt", 32'(h_gnt), 32'd1);
    chk("drop_m_addr", 32'(m_addr), 32'h020);
    chk("drop_c_rvalid", 32'(c_rvalid), 32'(!RR));
    cyc(1, 0, 9'h010, 32'h0, 0, 0, 9'h020, 32'h0);
    chk("back_c_gnt", 32'(c_gnt), 32'd1);
    chk("back_h_rdata", h_rdata, 32'hCAFEF00D);

    // Contest: core write vs host read
    cyc(1, 1, 9'h030, 32'hA5A5A5A5, 1, 0, 9'h020, 32'h0);
    chk("cont_h_gnt", 32'(h_gnt), 32'(RR));
    chk("cont_m_wr", 32'(m_wr), 32'(!RR));
    chk("cont_c_stall", 32'(c_stall), 32'(RR));
    chk("cont_c_rdata", c_rdata, 32'hDEADBEEF);
    cyc(RR, 1, 9'h030, 32'hA5A5A5A5, !RR, 0, 9'h020, 32'h0);
    chk("cont2_c_gnt", 32'(c_gnt), 32'(RR));
    chk("cont2_m_rd", 32'(m_rd), 32'(!RR));
    chk("cont2_h_rdata", h_rdata, RR ? 32'hCAFEF00D : 32'h0);
    chk("cont2_c_rvalid", 32'(c_rvalid), 32'd0);
    cyc(0, 0, 9'h000, 32'h0, 0, 0, 9'h000, 32'h0);
    chk("cont3_h_rdata", h_rdata, RR ? 32'h0 : 32'hCAFEF00D);
    chk("cont3_c_rvalid", 32'(c_rvalid), 32'd0);
    chk("idle_m_addr", 32'(m_addr), 32'h0);
    cyc(1, 0, 9'h030, 32'h0, 0, 0, 9'h000, 32'h0);
    chk("wchk_c_gnt", 32'(c_gnt), 32'd1);
    cyc(0, 0, 9'h000, 32'h0, 0, 0, 9'h000, 32'h0);
    chk("wchk_c_rdata", c_rdata, 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
